// File: rtl/uart_boot_loader_if.sv
// Memory write port of the UART boot loader.
//   mem_addr     : word address of the current write
//   mem_data_out : write data, little-endian assembled from the UART stream
//   mem_wes      : byte write enables, all ones for exactly one cycle per word
// master = boot loader (drives), slave = instruction memory (receives).
interface uart_boot_loader_if #(
  parameter int unsigned M_WIDTH = 32
);
  logic [M_WIDTH-3:0]   mem_addr;
  logic [M_WIDTH-1:0]   mem_data_out;
  logic [M_WIDTH/8-1:0] mem_wes;

  modport master (output mem_addr, output mem_data_out, output mem_wes);
  modport slave  (input  mem_addr, input  mem_data_out, input  mem_wes);
endinterface

// File: rtl/uart_boot_loader.sv
// UART (8N1) boot loader: receives a length-prefixed program image and writes
// it word by word into instruction memory, holding the CPU in reset until done.
//   clk, rst : system clock, asynchronous active-low reset
//   rx       : UART receive line (idle high, asynchronous to clk)
//   mem      : memory write port (uart_boot_loader_if.master)
//   cpu_rst  : high holds the CPU in reset
//   busy     : loading in progress (first byte seen, not yet done/err)
//   done     : image loaded, sticky until reset
//   err      : framing or length error, sticky until reset
module uart_boot_loader #(
  parameter int unsigned M_WIDTH      = 32,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MAX_WORDS    = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  uart_boot_loader_if.master  mem,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = M_WIDTH - 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_LEN, L_DATA, L_WRITE, L_DONE, L_ERR} ld_state_t;

  rx_state_t         rx_state;
  ld_state_t         ld_state;
  logic              rx_meta, rx_s;
  logic [CW-1:0]     cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic              byte_valid, frame_err;
  logic [1:0]        byte_cnt;
  logic [M_WIDTH-1:0] data_acc, word_cnt, asm_word;
  logic [IW-1:0]     idx;

  // Two-flop synchroniser; reset to idle-high so reset release is not a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Byte receiver: start bit re-checked at mid-bit, then one sample per bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (!rx_s) begin
            cnt      <= '0;
            rx_state <= R_START;
          end
        end
        R_START: begin
          if (cnt == CNT_HALF) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= R_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            rx_state <= R_IDLE;
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: rx_state <= R_IDLE;
      endcase
    end
  end

  // Little-endian assembly: each new byte enters at the top, oldest byte ends in [7:0].
  assign asm_word = {shreg, data_acc[M_WIDTH-1:8]};

  // Loader: length word, then data words, one single-cycle write per word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state         <= L_LEN;
      byte_cnt         <= '0;
      data_acc         <= '0;
      word_cnt         <= '0;
      idx              <= '0;
      mem.mem_addr     <= '0;
      mem.mem_data_out <= '0;
      mem.mem_wes      <= '0;
      cpu_rst          <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      case (ld_state)
        L_LEN, L_DATA, L_WRITE: begin
          if (frame_err) begin
            ld_state    <= L_ERR;
            err         <= 1'b1;
            busy        <= 1'b0;
            mem.mem_wes <= '0;
          end else if (ld_state == L_WRITE) begin
            mem.mem_wes <= '0;
            idx         <= idx + IW'(1);
            if (M_WIDTH'(idx) + M_WIDTH'(1) == word_cnt) begin
              ld_state <= L_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_rst  <= 1'b0;
            end else begin
              ld_state <= L_DATA;
            end
          end else if (byte_valid) begin
            busy     <= 1'b1;
            byte_cnt <= byte_cnt + 2'd1;
            data_acc <= asm_word;
            if (byte_cnt == 2'd3) begin
              if (ld_state == L_LEN) begin
                word_cnt <= asm_word;
                idx      <= '0;
                if (asm_word == '0) begin
                  ld_state <= L_DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_rst  <= 1'b0;
                end else if (asm_word > M_WIDTH'(MAX_WORDS)) begin
                  ld_state <= L_ERR;
                  err      <= 1'b1;
                  busy     <= 1'b0;
                end else begin
                  ld_state <= L_DATA;
                end
              end else begin
                mem.mem_data_out <= asm_word;
                mem.mem_addr     <= idx;
                mem.mem_wes      <= '1;
                ld_state         <= L_WRITE;
              end
            end
          end
        end
        // Terminal states: bytes and framing errors are ignored until reset.
        L_DONE, L_ERR: ld_state <= ld_state;
        default: ld_state <= L_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table of byte streams with expected
// end state, a write scoreboard fed from the table, and hand-written sequences
// for async reset, glitch rejection and mid-byte reset.
module tb_uart_boot_loader;
  localparam int unsigned CPB  = 4;
  localparam int unsigned MAXW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic cpu_rst, busy, done, err;

  always #5 clk = ~clk;

  uart_boot_loader_if #(.M_WIDTH(32)) mem_if ();

  uart_boot_loader #(.M_WIDTH(32), .CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .mem(mem_if),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    string           name;
    int              n;
    logic [7:0]      b [40];
    int              bad;
    logic            exp_done;
    logic            exp_err;
    int              exp_nwr;
  } vec_t;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } wr_t;

  vec_t tbl [8];
  wr_t  q [$];
  wr_t  mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every enabled write must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (rst && mem_if.mem_wes != 4'h0) begin
      wr_cnt++;
      check("wr_wes", 64'(mem_if.mem_wes), 64'h0F);
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                 mem_if.mem_addr, mem_if.mem_data_out);
      end else begin
        mon_e = q.pop_front();
        check("wr_addr", 64'(mem_if.mem_addr), 64'(mon_e.a));
        check("wr_data", 64'(mem_if.mem_data_out), 64'(mon_e.d));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    wr_cnt = 0;
  endtask

  task automatic put_word(input int v, input int i, input logic [31:0] w);
    for (int k = 0; k < 4; k++) tbl[v].b[i+k] = w[8*k +: 8];
  endtask

  task automatic push_writes(input int v);
    wr_t e;
    for (int k = 0; k < tbl[v].exp_nwr; k++) begin
      e.a = 30'(k);
      e.d = {tbl[v].b[4*k+7], tbl[v].b[4*k+6], tbl[v].b[4*k+5], tbl[v].b[4*k+4]};
      q.push_back(e);
    end
  endtask

  task automatic send_two_word();
    wr_t e;
    e.a = 30'd0; e.d = 32'h0010_0513; q.push_back(e);
    e.a = 30'd1; e.d = 32'h0000_006F; q.push_back(e);
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h6F, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic check_end(input string nm, input logic e_done, input logic e_err, input int e_nwr);
    check({nm, "_done"},    64'(done),    64'(e_done));
    check({nm, "_err"},     64'(err),     64'(e_err));
    check({nm, "_cpu_rst"}, 64'(cpu_rst), 64'(!e_done));
    check({nm, "_busy"},    64'(busy),    64'h0);
    check({nm, "_nwr"},     64'(wr_cnt),  64'(e_nwr));
    check({nm, "_pending"}, 64'(q.size()), 64'h0);
  endtask

  initial begin
    for (int v = 0; v < 8; v++) begin
      tbl[v].b   = '{default: 8'h00};
      tbl[v].bad = -1;
    end
    tbl[0].name = "two_word";  tbl[0].n = 12;
    put_word(0, 0, 32'd2); put_word(0, 4, 32'h0010_0513); put_word(0, 8, 32'h0000_006F);
    tbl[0].exp_done = 1; tbl[0].exp_err = 0; tbl[0].exp_nwr = 2;
    tbl[1].name = "zero_len";  tbl[1].n = 4;
    tbl[1].exp_done = 1; tbl[1].exp_err = 0; tbl[1].exp_nwr = 0;
    tbl[2].name = "oversize";  tbl[2].n = 5;
    put_word(2, 0, 32'd9); tbl[2].b[4] = 8'h13;
    tbl[2].exp_done = 0; tbl[2].exp_err = 1; tbl[2].exp_nwr = 0;
    tbl[3].name = "frame_data"; tbl[3].n = 8; tbl[3].bad = 5;
    put_word(3, 0, 32'd2); put_word(3, 4, 32'h0010_0513);
    tbl[3].exp_done = 0; tbl[3].exp_err = 1; tbl[3].exp_nwr = 0;
    tbl[4].name = "max_words"; tbl[4].n = 36;
    put_word(4, 0, 32'd8);
    for (int k = 0; k < 32; k++) tbl[4].b[4+k] = 8'(k * 37 + 11);
    tbl[4].exp_done = 1; tbl[4].exp_err = 0; tbl[4].exp_nwr = 8;
    tbl[5].name = "trailing";  tbl[5].n = 10;
    put_word(5, 0, 32'd1); put_word(5, 4, 32'hDDCC_BBAA); tbl[5].b[8] = 8'hEE; tbl[5].b[9] = 8'hFF;
    tbl[5].exp_done = 1; tbl[5].exp_err = 0; tbl[5].exp_nwr = 1;
    tbl[6].name = "frame_len"; tbl[6].n = 4; tbl[6].bad = 1;
    put_word(6, 0, 32'd2);
    tbl[6].exp_done = 0; tbl[6].exp_err = 1; tbl[6].exp_nwr = 0;
    tbl[7].name = "frame_done"; tbl[7].n = 5; tbl[7].bad = 4;
    tbl[7].b[4] = 8'h55;
    tbl[7].exp_done = 1; tbl[7].exp_err = 0; tbl[7].exp_nwr = 0;

    // Async reset with no clock edge in between.
    #2 rst = 1'b0;
    #1;
    check("rst_addr",    64'(mem_if.mem_addr),     64'h0);
    check("rst_data",    64'(mem_if.mem_data_out), 64'h0);
    check("rst_wes",     64'(mem_if.mem_wes),      64'h0);
    check("rst_cpu_rst", 64'(cpu_rst), 64'h1);
    check("rst_busy",    64'(busy),    64'h0);
    check("rst_done",    64'(done),    64'h0);
    check("rst_err",     64'(err),     64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 8; v++) begin
      do_reset();
      push_writes(v);
      for (int i = 0; i < tbl[v].n; i++) send_byte(tbl[v].b[i], (i == tbl[v].bad) ? 1'b0 : 1'b1);
      repeat (20) @(negedge clk);
      check_end(tbl[v].name, tbl[v].exp_done, tbl[v].exp_err, tbl[v].exp_nwr);
    end

    // Busy after the first byte, CPU still held.
    do_reset();
    send_byte(8'h03, 1'b1);
    repeat (4) @(negedge clk);
    check("first_byte_busy",    64'(busy),    64'h1);
    check("first_byte_cpu_rst", 64'(cpu_rst), 64'h1);

    // Full load, final write port values held, then async reset clears them.
    do_reset();
    send_two_word();
    check_end("hold", 1'b1, 1'b0, 2);
    check("hold_addr", 64'(mem_if.mem_addr),     64'h1);
    check("hold_data", 64'(mem_if.mem_data_out), 64'h6F);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_addr",    64'(mem_if.mem_addr),     64'h0);
    check("async_data",    64'(mem_if.mem_data_out), 64'h0);
    check("async_done",    64'(done),    64'h0);
    check("async_cpu_rst", 64'(cpu_rst), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    wr_cnt = 0;

    // One-cycle low glitch on an idle line.
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", 64'(busy), 64'h0);
    check("glitch_err",  64'(err),  64'h0);
    check("glitch_done", 64'(done), 64'h0);

    // Reset in the middle of byte 6, then a clean reload.
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h13, 1'b1);
    check("midbyte_busy_before", 64'(busy), 64'h1);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rx = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("midbyte_busy",    64'(busy),    64'h0);
    check("midbyte_cpu_rst", 64'(cpu_rst), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_two_word();
    check_end("reload", 1'b1, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits beside the CPU core at SoC top level, directly upstream of its instruction memory.
- Receives a program image over UART RX (8N1) and writes it word-by-word into memory through a word-addressed, byte-enabled write port.
- Holds the CPU in reset until the image is loaded, then releases it.
- Completes the on-chip UART path, whose TX side already exists.

Parameters:
- M_WIDTH, 32: memory word width in bits; must be 32.
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- MAX_WORDS, 4096: largest accepted image, in words.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  UART receive line; idle high; asynchronous to clk.
- mem_addr  output  M_WIDTH-2  word address of the current write.
- mem_data_out  output  M_WIDTH  write data, little-endian assembled.
- mem_wes  output  M_WIDTH/8  byte write enables.
- cpu_rst  output  1  high holds the CPU in reset.
- busy  output  1  high once the first byte is received, until DONE or ERROR.
- done  output  1  image loaded; sticky until reset.
- err  output  1  framing or length error; sticky until reset.

Behaviour:
- Reset (rst low, async) drives all outputs immediately to:
  - mem_addr=0, mem_data_out=0, mem_wes=0
  - cpu_rst=1, busy=0, done=0, err=0
  - both FSMs to IDLE/LEN, all counters 0.
- rx synchronisation: rx passes through a 2-flop synchroniser before any use. All timing below refers to the synchronised signal.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: a low level starts the bit counter, then go to R_START.
  - R_START: at count CLKS_PER_BIT/2 (integer division), sample rx.
    - If high, it is a glitch: return to R_IDLE with no byte and no error.
    - If low, go to R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, then go to R_STOP.
  - R_STOP: one CLKS_PER_BIT later, sample the stop bit.
    - If 1, pulse byte_valid for one cycle, then go to R_IDLE.
    - If 0, framing error.
- Loader FSM states: L_LEN, L_DATA, L_WRITE, L_DONE, L_ERR.
  - L_LEN: collect 4 bytes into word count N, little-endian (first byte = bits 7:0).
    - N==0: go to L_DONE.
    - N>MAX_WORDS: go to L_ERR.
    - Otherwise go to L_DATA with word index 0.
  - L_DATA: collect 4 bytes little-endian into mem_data_out. The 4th byte_valid moves the FSM to L_WRITE.
  - L_WRITE: lasts exactly one cycle.
    - mem_wes=all ones; mem_addr=word index; mem_data_out is stable.
    - Next cycle: mem_wes=0 and index+1.
    - If index+1==N, go to L_DONE; else go to L_DATA.
  - Write latency: mem_wes rises on the clock edge after the 4th byte_valid. Bytes cannot arrive faster than 10*CLKS_PER_BIT, so no byte is ever lost during a write.
  - L_DONE: done=1, busy=0. cpu_rst falls on the cycle L_DONE is entered. Further RX bytes are received but ignored; mem_wes stays 0.
  - L_ERR: err=1, busy=0, cpu_rst stays 1, mem_wes=0. Only reset exits this state.
- Framing error in any loader state other than L_DONE goes to L_ERR. In L_DONE it is ignored.
- mem_addr and mem_data_out hold their last value outside L_WRITE.
- busy: rises on the first byte_valid; falls on entry to L_DONE or L_ERR.
- Mid-frame reset: a partial byte or word is discarded, and the loader restarts at L_LEN.
- No timeout: an idle line leaves the block waiting indefinitely with cpu_rst=1.

Test Plan:
- Bench uses CLKS_PER_BIT=4, MAX_WORDS=8.
- Two-word image: send length 02 00 00 00, then bytes 13 05 10 00, 6F 00 00 00 ->
  - write 1: addr 0, data 0x00100513, wes 4'hF, one cycle;
  - write 2: addr 1, data 0x0000006F;
  - then cpu_rst=0, done=1, err=0.
- Zero length: send 00 00 00 00 -> done=1, cpu_rst=0, no mem_wes pulse ever.
- Oversize: send length 09 00 00 00 -> err=1, cpu_rst=1, no writes; a following data byte causes no change.
- Framing error: 2nd data byte sent with stop bit 0 -> err=1, no write, cpu_rst stays 1.
- Glitch and reset: a 1-cycle low pulse on rx in R_IDLE produces no byte and no error. Asserting rst low mid-byte 6 clears everything asynchronously; a full resend of the two-word image then loads correctly.
